// File: rtl/axilite_pkg.sv
// Shared types and helpers for the AXI4-Lite to APB bridge.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

  // True when addr falls inside [base, base+size).
  function automatic logic apb_in_window(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// APB wait-state watchdog; only built when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;

  // expired_o rises in the TIMEOUT_CYCLES-th cycle that start_i is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_o <= 1'b0;
    end else if (clear_i) begin
      cnt_q     <= '0;
      expired_o <= 1'b0;
    end else if (start_i) begin
      cnt_q     <= cnt_q + CNT_W'(1);
      expired_o <= (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));
    end
  end

endmodule
`endif

// File: rtl/axilite_apb_bridge.sv
// AXI4-Lite responder forwarding one transaction at a time as an APB transfer.
// Optional APB wait-state timeout: define APB_TIMEOUT_EN.
module axilite_apb_bridge
  import axilite_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter logic [31:0] APB_BASE       = 32'h0,
  parameter logic [31:0] APB_SIZE       = 32'h1000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic [ADDR_W-1:0] m_apb_paddr,
  output logic              m_apb_psel,
  output logic              m_apb_penable,
  output logic              m_apb_pwrite,
  output logic [31:0]       m_apb_pwdata,
  output logic [3:0]        m_apb_pstrb,
  input  logic [31:0]       m_apb_prdata,
  input  logic              m_apb_pready,
  input  logic              m_apb_pslverr
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  bridge_state_e     state_q;
  logic              is_wr_q, last_wr_q;
  logic              aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_full_d, w_full_d, ar_full_d;
  logic              aw_hs, w_hs, ar_hs, wr_pend, rd_pend, grant_wr, grant_hit;
  logic              idle_go, access_done, free_wr, free_rd, expired;
  logic [ADDR_W-1:0] grant_addr;
  logic [1:0]        resp_c;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (s_axi_aclk),
    .rst_n    (s_axi_aresetn),
    .start_i  (state_q == ST_ACCESS),
    .clear_i  (state_q != ST_ACCESS),
    .expired_o(expired)
  );
`else
  assign expired = 1'b0;
`endif

  // Arbitration, window decode and capture-slot bookkeeping.
  always_comb begin
    aw_hs       = s_axi_awvalid && s_axi_awready;
    w_hs        = s_axi_wvalid && s_axi_wready;
    ar_hs       = s_axi_arvalid && s_axi_arready;
    wr_pend     = aw_full_q && w_full_q;
    rd_pend     = ar_full_q;
    grant_wr    = wr_pend && !(rd_pend && last_wr_q);
    grant_addr  = grant_wr ? awaddr_q : araddr_q;
    grant_hit   = apb_in_window(32'(grant_addr), APB_BASE, APB_SIZE);
    idle_go     = (state_q == ST_IDLE) && (wr_pend || rd_pend);
    access_done = (state_q == ST_ACCESS) && (m_apb_pready || expired);
    free_wr     = (idle_go && grant_wr && !grant_hit) || (access_done && is_wr_q);
    free_rd     = (idle_go && !grant_wr && !grant_hit) || (access_done && !is_wr_q);
    aw_full_d   = (aw_full_q || aw_hs) && !free_wr;
    w_full_d    = (w_full_q || w_hs) && !free_wr;
    ar_full_d   = (ar_full_q || ar_hs) && !free_rd;
    resp_c      = (m_apb_pready && !m_apb_pslverr) ? RESP_OKAY : RESP_SLVERR;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      aw_full_q     <= 1'b0;
      w_full_q      <= 1'b0;
      ar_full_q     <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
    end else begin
      aw_full_q     <= aw_full_d;
      w_full_q      <= w_full_d;
      ar_full_q     <= ar_full_d;
      s_axi_awready <= !aw_full_d;
      s_axi_wready  <= !w_full_d;
      s_axi_arready <= !ar_full_d;
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (ar_hs) araddr_q <= s_axi_araddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
    end
  end

  // Bridge FSM; every AXI response and APB signal is a register.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= ST_IDLE;
      is_wr_q       <= 1'b0;
      last_wr_q     <= 1'b0;
      m_apb_psel    <= 1'b0;
      m_apb_penable <= 1'b0;
      m_apb_pwrite  <= 1'b0;
      m_apb_paddr   <= '0;
      m_apb_pwdata  <= '0;
      m_apb_pstrb   <= '0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (idle_go) begin
          is_wr_q <= grant_wr;
          if (wr_pend && rd_pend) last_wr_q <= grant_wr;
          if (grant_hit) begin
            state_q      <= ST_SETUP;
            m_apb_psel   <= 1'b1;
            m_apb_pwrite <= grant_wr;
            m_apb_paddr  <= grant_addr;
            m_apb_pwdata <= grant_wr ? wdata_q : 32'h0;
            m_apb_pstrb  <= grant_wr ? wstrb_q : 4'hF;
          end else begin
            state_q <= ST_RESP;
            if (grant_wr) begin
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= RESP_DECERR;
            end else begin
              s_axi_rvalid <= 1'b1;
              s_axi_rresp  <= RESP_DECERR;
              s_axi_rdata  <= '0;
            end
          end
        end
        ST_SETUP: begin
          m_apb_penable <= 1'b1;
          state_q       <= ST_ACCESS;
        end
        ST_ACCESS: if (access_done) begin
          m_apb_psel    <= 1'b0;
          m_apb_penable <= 1'b0;
          state_q       <= ST_RESP;
          if (is_wr_q) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= resp_c;
          end else begin
            s_axi_rvalid <= 1'b1;
            s_axi_rresp  <= resp_c;
            s_axi_rdata  <= m_apb_pready ? m_apb_prdata : 32'h0;
          end
        end
        ST_RESP: if (is_wr_q ? s_axi_bready : s_axi_rready) begin
          s_axi_bvalid <= 1'b0;
          s_axi_rvalid <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
